// File: rtl/aes128_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes128_pkg: shared types, RCON table and GF(2^8) helpers for AES-128       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes128_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } seqState_t;

   localparam int c_ROWS       = 4;
   localparam int c_COLS       = 4;
   localparam int c_NUM_ROUNDS = 10;

   // Indexed directly by the round number; entry 0 and 11..15 are unused.
   localparam logic [7:0] c_RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef logic [7:0] byteArr_t [c_ROWS][c_COLS];

   // MSB position on a 128-bit bus of the byte at array element (row, col).
   function automatic int byteMsb(input int row, input int col);
      return 127 - 8 * (c_ROWS * col + row);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (= product of a^2..a^128), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = a;
      for (int i = 1; i < 8; i++) begin
         sq  = gfMul(sq, sq);
         inv = gfMul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_key_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes128_key_step: combinational AES-128 next-round-key derivation           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes128_key_step
   import aes128_pkg::*;
(
   input  logic [127:0] i_key,
   input  logic [7:0]   i_rcon,
   output logic [127:0] o_nextKey
);

   logic [31:0] w_w3;
   logic [31:0] w_t;
   logic [31:0] w_n0, w_n1, w_n2, w_n3;

   assign w_w3 = i_key[31:0];
   assign w_t  = {sbox(w_w3[23:16]) ^ i_rcon, sbox(w_w3[15:8]),
                  sbox(w_w3[7:0]), sbox(w_w3[31:24])};

   assign w_n0 = i_key[127:96] ^ w_t;
   assign w_n1 = i_key[95:64]  ^ w_n0;
   assign w_n2 = i_key[63:32]  ^ w_n1;
   assign w_n3 = i_key[31:0]   ^ w_n2;

   assign o_nextKey = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes128_round_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes128_full_round / aes128_last_round: combinational round datapaths       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes128_full_round
   import aes128_pkg::*;
(
   input  byteArr_t i_stateRc,
   input  byteArr_t i_keyRc,
   output byteArr_t o_stateRc
);

   byteArr_t w_srRc;

   // SubBytes+ShiftRows fused, then MixColumns+AddRoundKey per column.
   for (genvar r = 0; r < c_ROWS; r++) begin : g_row
      for (genvar c = 0; c < c_COLS; c++) begin : g_col
         assign w_srRc[r][c] = sbox(i_stateRc[r][(c + r) % c_COLS]);
         assign o_stateRc[r][c] = xtime(w_srRc[r][c])
                                ^ xtime(w_srRc[(r + 1) % c_ROWS][c]) ^ w_srRc[(r + 1) % c_ROWS][c]
                                ^ w_srRc[(r + 2) % c_ROWS][c]
                                ^ w_srRc[(r + 3) % c_ROWS][c]
                                ^ i_keyRc[r][c];
      end
   end

endmodule

module aes128_last_round
   import aes128_pkg::*;
(
   input  byteArr_t i_stateRc,
   input  byteArr_t i_keyRc,
   output byteArr_t o_stateRc
);

   for (genvar r = 0; r < c_ROWS; r++) begin : g_row
      for (genvar c = 0; c < c_COLS; c++) begin : g_col
         assign o_stateRc[r][c] = sbox(i_stateRc[r][(c + r) % c_COLS]) ^ i_keyRc[r][c];
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes128_round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes128_round_sequencer: iterative AES-128 encrypt, one round per clock     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes128_round_sequencer
   import aes128_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_plain,
   input  logic [127:0] i_key,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_cipher,
   output logic         o_busy
);

   seqState_t    r_state;
   logic [127:0] r_st;
   logic [127:0] r_rk;
   logic [3:0]   r_rnd;
   logic         r_ready;
   logic         r_valid;
   logic         r_busy;

   logic [127:0] w_nextKey;
   logic [127:0] w_fullOut;
   logic [127:0] w_lastOut;
   byteArr_t     w_stRc;
   byteArr_t     w_keyRc;
   byteArr_t     w_fullRc;
   byteArr_t     w_lastRc;

   aes128_key_step u_keyStep (
      .i_key     (r_rk),
      .i_rcon    (c_RCON[r_rnd]),
      .o_nextKey (w_nextKey)
   );

   for (genvar r = 0; r < c_ROWS; r++) begin : g_row
      for (genvar c = 0; c < c_COLS; c++) begin : g_col
         localparam int c_MSB = byteMsb(r, c);
         assign w_stRc[r][c]            = r_st[c_MSB -: 8];
         assign w_keyRc[r][c]           = w_nextKey[c_MSB -: 8];
         assign w_fullOut[c_MSB -: 8]   = w_fullRc[r][c];
         assign w_lastOut[c_MSB -: 8]   = w_lastRc[r][c];
      end
   end

   aes128_full_round u_fullRound (
      .i_stateRc (w_stRc),
      .i_keyRc   (w_keyRc),
      .o_stateRc (w_fullRc)
   );

   aes128_last_round u_lastRound (
      .i_stateRc (w_stRc),
      .i_keyRc   (w_keyRc),
      .o_stateRc (w_lastRc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_st    <= '0;
         r_rk    <= '0;
         r_rnd   <= 4'd1;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_valid) begin
                  r_st    <= i_plain ^ i_key;
                  r_rk    <= i_key;
                  r_rnd   <= 4'd1;
                  r_state <= ROUND;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ROUND: begin
               r_rk <= w_nextKey;
               if (r_rnd == 4'(c_NUM_ROUNDS)) begin
                  r_st    <= w_lastOut;
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
               end else begin
                  r_st  <= w_fullOut;
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            DONE: begin
               // Returning to IDLE first keeps a new accept out of the DONE cycle.
               if (i_ready) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready  = r_ready;
   assign o_valid  = r_valid;
   assign o_busy   = r_busy;
   assign o_cipher = r_st;

endmodule
`default_nettype wire
